// File: rtl/blink_sequencer.sv
// blink_sequencer: prescaled LED pattern rotator with a valid/ready config port
module blink_sequencer #(
  parameter int WIDTH = 22,
  parameter int NLED = 4,
  parameter logic [WIDTH-1:0] DEFAULT_PERIOD = 22'h3FFFFF
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             RUN,
  input  logic             CFG_VALID,
  output logic             CFG_READY,
  input  logic [WIDTH-1:0] CFG_PERIOD,
  input  logic [NLED-1:0]  CFG_PATTERN,
  output logic [NLED-1:0]  LED,
  output logic             TICK,
  output logic             BUSY
);
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_LOAD = 2'd2;
  logic [1:0] r_state;
  logic [WIDTH-1:0] r_count, r_period;
  logic [NLED-1:0] r_pattern, r_led;
  logic r_tick, r_ready;
  logic w_hs, w_wrap;
  logic [NLED-1:0] w_rot;
  assign w_hs = CFG_VALID & r_ready;
  assign w_wrap = r_count == r_period;
  assign w_rot = (r_pattern << 1) | (r_pattern >> (NLED - 1));
  assign LED = r_led;
  assign TICK = r_tick;
  assign CFG_READY = r_ready;
  assign BUSY = r_state == S_RUN;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_period <= DEFAULT_PERIOD;
      r_pattern <= NLED'(1);
      r_led <= '0;
      r_tick <= 1'b0;
      r_ready <= 1'b1;
    end else if (w_hs) begin
      // config wins over a coincident wrap or RUN change
      r_state <= S_LOAD;
      r_period <= CFG_PERIOD;
      r_pattern <= CFG_PATTERN;
      r_count <= '0;
      r_tick <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_ready <= 1'b1;
      case (r_state)
        S_RUN: begin
          r_state <= RUN ? S_RUN : S_IDLE;
          r_led <= RUN ? r_pattern : '0;
          r_tick <= RUN & w_wrap;
          r_count <= (!RUN || w_wrap) ? '0 : r_count + 1'b1;
          if (RUN && w_wrap) r_pattern <= w_rot;
        end
        S_LOAD: begin
          r_state <= RUN ? S_RUN : S_IDLE;
          r_led <= RUN ? r_led : '0;
          r_tick <= 1'b0;
          r_count <= '0;
        end
        default: begin
          r_state <= RUN ? S_RUN : S_IDLE;
          r_led <= '0;
          r_tick <= 1'b0;
          r_count <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_blink_sequencer.sv
// tb_blink_sequencer: vector table, directed corner sequences and random run against a reference model
module tb_blink_sequencer;
  logic clk = 1'b0;
  logic rst, run, vld;
  logic [3:0] per, pat;
  logic rdy, tick, busy;
  logic [3:0] led;
  int n_tests = 0, n_fail = 0;
  int m_mode, m_cnt, m_per, m_base, m_rot, m_led, m_tick;
  typedef struct {
    logic rst, run, vld;
    logic [3:0] per, pat, led;
    logic tick, rdy, busy;
  } vec_t;
  vec_t tbl[21];

  always #5 clk = ~clk;

  blink_sequencer #(.WIDTH(4), .NLED(4), .DEFAULT_PERIOD(4'd3)) dut (
    .CLK(clk), .RESET(rst), .RUN(run), .CFG_VALID(vld), .CFG_READY(rdy),
    .CFG_PERIOD(per), .CFG_PATTERN(pat), .LED(led), .TICK(tick), .BUSY(busy)
  );

  function automatic int pat_now();
    int r = m_rot % 4;
    return ((m_base << r) | (m_base >> (4 - r))) & 15;
  endfunction

  task automatic model_edge();
    bit ready = m_mode != 2;
    if (rst) begin
      m_mode = 0; m_cnt = 0; m_per = 3; m_base = 1; m_rot = 0; m_led = 0; m_tick = 0;
    end else if (vld && ready) begin
      m_mode = 2; m_per = int'(per); m_base = int'(pat); m_rot = 0; m_cnt = 0; m_tick = 0;
    end else if (m_mode == 2) begin
      m_mode = run ? 1 : 0; m_led = run ? m_led : 0; m_tick = 0;
    end else if (m_mode == 1 && run) begin
      m_led = pat_now();
      m_tick = int'(m_cnt == m_per);
      if (m_tick == 1) begin m_cnt = 0; m_rot++; end else m_cnt++;
    end else begin
      m_mode = run ? 1 : 0; m_cnt = 0; m_led = 0; m_tick = 0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic u, input logic v, input logic [3:0] p, input logic [3:0] a);
    rst = r; run = u; vld = v; per = p; pat = a;
    @(posedge clk);
    model_edge();
    #1;
    chk("model_led", 32'(led), 32'(m_led));
    chk("model_tick", 32'(tick), 32'(m_tick));
    chk("model_ready", 32'(rdy), 32'(m_mode != 2));
    chk("model_busy", 32'(busy), 32'(m_mode == 1));
  endtask

  initial begin
    int n;
    rst = 1'b1; run = 1'b0; vld = 1'b0; per = '0; pat = '0;
    m_mode = 0; m_cnt = 0; m_per = 3; m_base = 1; m_rot = 0; m_led = 0; m_tick = 0;
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 1, 0};
    tbl[1]  = '{0, 0, 1, 5, 1, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 1, 6, 2, 0, 0, 1, 0};
    tbl[3]  = '{0, 0, 1, 2, 4, 0, 0, 0, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
    tbl[5]  = '{0, 1, 0, 0, 0, 0, 0, 1, 1};
    tbl[6]  = '{0, 1, 0, 0, 0, 4, 0, 1, 1};
    tbl[7]  = '{0, 1, 0, 0, 0, 4, 0, 1, 1};
    tbl[8]  = '{0, 1, 0, 0, 0, 4, 1, 1, 1};
    tbl[9]  = '{0, 1, 0, 0, 0, 8, 0, 1, 1};
    tbl[10] = '{1, 0, 0, 0, 0, 0, 0, 1, 0};
    tbl[11] = '{0, 1, 0, 0, 0, 0, 0, 1, 1};
    tbl[12] = '{0, 1, 0, 0, 0, 1, 0, 1, 1};
    tbl[13] = '{0, 1, 0, 0, 0, 1, 0, 1, 1};
    tbl[14] = '{0, 1, 0, 0, 0, 1, 0, 1, 1};
    tbl[15] = '{0, 1, 0, 0, 0, 1, 1, 1, 1};
    tbl[16] = '{0, 1, 0, 0, 0, 2, 0, 1, 1};
    tbl[17] = '{0, 1, 0, 0, 0, 2, 0, 1, 1};
    tbl[18] = '{0, 1, 0, 0, 0, 2, 0, 1, 1};
    tbl[19] = '{0, 1, 0, 0, 0, 2, 1, 1, 1};
    tbl[20] = '{0, 1, 0, 0, 0, 4, 0, 1, 1};
    for (int i = 0; i < 21; i++) begin
      step(tbl[i].rst, tbl[i].run, tbl[i].vld, tbl[i].per, tbl[i].pat);
      chk($sformatf("vec%0d_led", i), 32'(led), 32'(tbl[i].led));
      chk($sformatf("vec%0d_tick", i), 32'(tick), 32'(tbl[i].tick));
      chk($sformatf("vec%0d_ready", i), 32'(rdy), 32'(tbl[i].rdy));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
    end
    // RUN drop at LED=0100 then resume from the stored pattern
    step(0, 0, 0, 0, 0);
    chk("drop_led", 32'(led), 0);
    chk("drop_busy", 32'(busy), 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("resume_led", 32'(led), 4);
    repeat (3) step(0, 1, 0, 0, 0);
    chk("resume_tick", 32'(tick), 1);
    step(0, 1, 0, 0, 0);
    chk("resume_rot", 32'(led), 8);
    // period 0: rotate and tick every cycle
    step(0, 1, 1, 0, 4'b0101);
    chk("p0_ready_low", 32'(rdy), 0);
    step(0, 1, 0, 0, 0);
    chk("p0_ready_back", 32'(rdy), 1);
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 0, 0, 0);
      chk("p0_led", 32'(led), (k % 2) ? 10 : 5);
      chk("p0_tick", 32'(tick), 1);
    end
    // handshake coincident with the wrap edge
    step(0, 1, 1, 3, 1);
    step(0, 1, 0, 0, 0);
    n = 0;
    while (!(m_mode == 1 && m_cnt == m_per) && n < 20) begin step(0, 1, 0, 0, 0); n++; end
    chk("wrap_reached", 32'(n < 20), 1);
    step(0, 1, 1, 7, 4'b0011);
    chk("wrap_cfg_no_tick", 32'(tick), 0);
    n = 0;
    do begin step(0, 1, 0, 0, 0); n++; end while (!tick && n < 20);
    chk("wrap_cfg_gap", n, 9);
    chk("wrap_cfg_led", 32'(led), 3);
    // reset during LOAD discards the pending config
    step(0, 1, 1, 9, 6);
    step(1, 1, 0, 0, 0);
    chk("rst_load_led", 32'(led), 0);
    chk("rst_load_ready", 32'(rdy), 1);
    chk("rst_load_busy", 32'(busy), 0);
    repeat (8) step(0, 1, 0, 0, 0);
    // maximum period and all-zero pattern
    step(0, 1, 1, 15, 8);
    repeat (40) step(0, 1, 0, 0, 0);
    step(0, 1, 1, 2, 0);
    repeat (10) step(0, 1, 0, 0, 0);
    chk("zero_pat_led", 32'(led), 0);
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 11) == 0,
           4'($urandom_range(0, 3) == 0 ? $urandom_range(0, 15) : $urandom_range(0, 3)),
           4'($urandom_range(0, 15)));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
